// File: rtl/ro_dep_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// cpu_sb_pkg
// Shared constants and helpers for the read-operands pending-write scoreboard.
//   REG_ID_W      width of a register identifier (3 bits -> 8 registers/file)
//   MAX_REGS      number of registers addressable by one identifier
//   EAX_ID/ECX_ID well-known GPR identifiers
//   DEF_NUM_*     default register counts tracked per file
//   DEF_CNT_W     default width of each pending-write counter
//   dest_onehot() turns a (id, valid) destination into a one-hot vector
// Optional feature macro used by this slice: SB_WB_BYPASS_EN
// ---------------------------------------------------------------------------
package cpu_sb_pkg;

    localparam int REG_ID_W    = 3;
    localparam int MAX_REGS    = 1 << REG_ID_W;
    localparam int EAX_ID      = 0;
    localparam int ECX_ID      = 1;
    localparam int DEF_NUM_GPR = 8;
    localparam int DEF_NUM_MM  = 8;
    localparam int DEF_NUM_SEG = 8;
    localparam int DEF_CNT_W   = 2;

    // A destination that is not valid contributes an all-zero vector, so
    // several slots can simply be OR'd together by the caller.
    function automatic logic [MAX_REGS-1:0] dest_onehot(input logic [REG_ID_W-1:0] id,
                                                        input logic                valid);
        logic [MAX_REGS-1:0] vec;
        vec = '0;
        if (valid) begin
            vec[id] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/ro_dep_scoreboard_if.sv
// ---------------------------------------------------------------------------
// ro_dep_scoreboard_if
// Bundles the issue (RO), retire (WB), flush and busy-status signals of the
// pending-write scoreboard.
//   master : pipeline side, drives issue/retire/flush, reads busy vectors
//   slave  : scoreboard side, reads issue/retire/flush, drives busy vectors
// Signals:
//   iss_v, iss_dreg1..3/iss_ld_reg1..3, iss_dmm/iss_ld_mm, iss_dseg/iss_ld_seg
//   wb_v,  wb_dreg1..3/wb_ld_reg1..3,   wb_dmm/wb_ld_mm,   wb_dseg/wb_ld_seg
//   flush, gpr_busy, mm_busy, seg_busy, sb_err
// ---------------------------------------------------------------------------
interface ro_dep_scoreboard_if
    import cpu_sb_pkg::*;
#(
    parameter int NUM_GPR = DEF_NUM_GPR,
    parameter int NUM_MM  = DEF_NUM_MM,
    parameter int NUM_SEG = DEF_NUM_SEG
);

    logic                iss_v;
    logic [REG_ID_W-1:0] iss_dreg1, iss_dreg2, iss_dreg3;
    logic                iss_ld_reg1, iss_ld_reg2, iss_ld_reg3;
    logic [REG_ID_W-1:0] iss_dmm, iss_dseg;
    logic                iss_ld_mm, iss_ld_seg;

    logic                wb_v;
    logic [REG_ID_W-1:0] wb_dreg1, wb_dreg2, wb_dreg3;
    logic                wb_ld_reg1, wb_ld_reg2, wb_ld_reg3;
    logic [REG_ID_W-1:0] wb_dmm, wb_dseg;
    logic                wb_ld_mm, wb_ld_seg;

    logic                flush;

    logic [NUM_GPR-1:0]  gpr_busy;
    logic [NUM_MM-1:0]   mm_busy;
    logic [NUM_SEG-1:0]  seg_busy;
    logic                sb_err;

    modport master (
        output iss_v, iss_dreg1, iss_dreg2, iss_dreg3,
               iss_ld_reg1, iss_ld_reg2, iss_ld_reg3,
               iss_dmm, iss_ld_mm, iss_dseg, iss_ld_seg,
               wb_v, wb_dreg1, wb_dreg2, wb_dreg3,
               wb_ld_reg1, wb_ld_reg2, wb_ld_reg3,
               wb_dmm, wb_ld_mm, wb_dseg, wb_ld_seg,
               flush,
        input  gpr_busy, mm_busy, seg_busy, sb_err
    );

    modport slave (
        input  iss_v, iss_dreg1, iss_dreg2, iss_dreg3,
               iss_ld_reg1, iss_ld_reg2, iss_ld_reg3,
               iss_dmm, iss_ld_mm, iss_dseg, iss_ld_seg,
               wb_v, wb_dreg1, wb_dreg2, wb_dreg3,
               wb_ld_reg1, wb_ld_reg2, wb_ld_reg3,
               wb_dmm, wb_ld_mm, wb_dseg, wb_ld_seg,
               flush,
        output gpr_busy, mm_busy, seg_busy, sb_err
    );

endinterface

// File: rtl/ro_dep_scoreboard_counter_bank.sv
// ---------------------------------------------------------------------------
// sb_counter_bank
// One saturating pending-write counter per register of a single register
// file, plus a sticky error flag for overflow/underflow.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   flush        discard all pending writes (error flag is kept)
//   inc[N]       a write to register i left RO this cycle
//   dec[N]       a write to register i committed in WB this cycle
//   busy[N]      register i has an outstanding write
//   err          sticky overflow/underflow flag
// Macro SB_WB_BYPASS_EN: when defined, busy also drops combinationally for a
// register whose last pending write commits in the current cycle.
// ---------------------------------------------------------------------------
module sb_counter_bank #(
    parameter int N     = 8,
    parameter int CNT_W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [N-1:0] inc,
    input  logic [N-1:0] dec,
    output logic [N-1:0] busy,
    output logic         err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    logic             err_q;
    logic             err_d;

    // Next-count logic. Flush wins over any issue/retire activity in the
    // same cycle, and that ignored activity cannot raise the error flag.
    // Simultaneous inc and dec cancel out, so they never trip saturation.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (flush) begin
                cnt_d[i] = '0;
            end else if (inc[i] && !dec[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else if (dec[i] && !inc[i]) begin
                if (cnt_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_ONE;
                end
            end
        end
    end

    // Counter and error registers; reset beats flush and everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Busy view. The bypass lets RO read a register in the same cycle its
    // final outstanding write retires instead of waiting one more cycle.
    always_comb begin
        for (int i = 0; i < N; i++) begin
`ifdef SB_WB_BYPASS_EN
            busy[i] = (cnt_q[i] != '0) &&
                      !((cnt_q[i] == CNT_ONE) && dec[i] && !inc[i]);
`else
            busy[i] = (cnt_q[i] != '0);
`endif
        end
    end

    assign err = err_q;

endmodule

// File: rtl/ro_dep_scoreboard.sv
// ---------------------------------------------------------------------------
// ro_dep_scoreboard
// Producer-side pending-write tracker between RO (issue) and WB (retire).
// Destination writes are counted per register as instructions leave RO and
// released when they commit in WB; the resulting busy vectors let the RO
// dependency logic stall without comparing every EX/WB destination.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   sb         ro_dep_scoreboard_if.slave: issue/retire/flush inputs,
//              gpr_busy/mm_busy/seg_busy/sb_err outputs
// Macro SB_WB_BYPASS_EN: combinational release of a register whose last
// pending write commits this cycle (see sb_counter_bank).
// Register files are limited to MAX_REGS entries (3-bit identifiers).
// ---------------------------------------------------------------------------
module ro_dep_scoreboard
    import cpu_sb_pkg::*;
#(
    parameter int NUM_GPR = DEF_NUM_GPR,
    parameter int NUM_MM  = DEF_NUM_MM,
    parameter int NUM_SEG = DEF_NUM_SEG,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    ro_dep_scoreboard_if.slave  sb
);

    logic [MAX_REGS-1:0] gpr_inc, gpr_dec;
    logic [MAX_REGS-1:0] mm_inc,  mm_dec;
    logic [MAX_REGS-1:0] seg_inc, seg_dec;
    logic                gpr_err, mm_err, seg_err;

    // Build the per-register increment/decrement vectors. OR-ing the GPR
    // slots means a destination repeated within one instruction counts once,
    // and the ld_* qualifiers are only honoured when the stage strobe is set.
    always_comb begin
        gpr_inc = '0;
        mm_inc  = '0;
        seg_inc = '0;
        gpr_dec = '0;
        mm_dec  = '0;
        seg_dec = '0;
        if (sb.iss_v) begin
            gpr_inc = dest_onehot(sb.iss_dreg1, sb.iss_ld_reg1) |
                      dest_onehot(sb.iss_dreg2, sb.iss_ld_reg2) |
                      dest_onehot(sb.iss_dreg3, sb.iss_ld_reg3);
            mm_inc  = dest_onehot(sb.iss_dmm,  sb.iss_ld_mm);
            seg_inc = dest_onehot(sb.iss_dseg, sb.iss_ld_seg);
        end
        if (sb.wb_v) begin
            gpr_dec = dest_onehot(sb.wb_dreg1, sb.wb_ld_reg1) |
                      dest_onehot(sb.wb_dreg2, sb.wb_ld_reg2) |
                      dest_onehot(sb.wb_dreg3, sb.wb_ld_reg3);
            mm_dec  = dest_onehot(sb.wb_dmm,  sb.wb_ld_mm);
            seg_dec = dest_onehot(sb.wb_dseg, sb.wb_ld_seg);
        end
    end

    sb_counter_bank #(.N(NUM_GPR), .CNT_W(CNT_W)) u_gpr_bank (
        .clk   (clk),
        .rst   (rst),
        .flush (sb.flush),
        .inc   (gpr_inc[NUM_GPR-1:0]),
        .dec   (gpr_dec[NUM_GPR-1:0]),
        .busy  (sb.gpr_busy),
        .err   (gpr_err)
    );

    sb_counter_bank #(.N(NUM_MM), .CNT_W(CNT_W)) u_mm_bank (
        .clk   (clk),
        .rst   (rst),
        .flush (sb.flush),
        .inc   (mm_inc[NUM_MM-1:0]),
        .dec   (mm_dec[NUM_MM-1:0]),
        .busy  (sb.mm_busy),
        .err   (mm_err)
    );

    sb_counter_bank #(.N(NUM_SEG), .CNT_W(CNT_W)) u_seg_bank (
        .clk   (clk),
        .rst   (rst),
        .flush (sb.flush),
        .inc   (seg_inc[NUM_SEG-1:0]),
        .dec   (seg_dec[NUM_SEG-1:0]),
        .busy  (sb.seg_busy),
        .err   (seg_err)
    );

    // Any bank detecting a mis-balanced counter flags the whole scoreboard.
    assign sb.sb_err = gpr_err | mm_err | seg_err;

endmodule
